adder_seven_seg: RTL and testbench

//  - Registered 4-bit adder feeding a hex seven-segment decoder.
//  - Sums two nibbles, reports the 4-bit sum and carry, and drives segments a..g showing the sum as hex 0-F.
//  - Sits between operand sources (switches or upstream logic) and a single-digit 7-seg display.

---
 rtl/adder_seven_seg_pkg.sv | 28 ++
 rtl/adder_seven_seg_seg7_decode.sv | 36 +++
 rtl/adder_seven_seg.sv | 91 +++++++++
 tb/tb_adder_seven_seg.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/adder_seven_seg_pkg.sv
// Shared definitions for the adder + seven-segment display block.
// Contents:
//   seg_t          7-bit segment pattern, bit order {a,b,c,d,e,f,g}
//   SEG_0..SEG_F   active-high patterns for hex digits 0-F
//   SEG_BLANK      all segments off (active-high)
package adder_seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b0011111;
  localparam seg_t SEG_C     = 7'b1001110;
  localparam seg_t SEG_D     = 7'b0111101;
  localparam seg_t SEG_E     = 7'b1001111;
  localparam seg_t SEG_F     = 7'b1000111;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/adder_seven_seg_seg7_decode.sv
// Combinational hex nibble to seven-segment decoder (active-high patterns).
// Ports:
//   nibble  in   4  value to display, 0-F
//   seg     out  7  pattern {a,b,c,d,e,f,g}, 1 = lit
// Output polarity is decided by the instantiating module, not here.
module seg7_decode
  import adder_seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/adder_seven_seg.sv
// Registered 4-bit adder driving a single hex seven-segment digit.
// Ports:
//   clk            in   1  rising-edge clock
//   rst_n          in   1  asynchronous active-low reset
//   in_valid       in   1  capture enable for input1/input2
//   input1,input2  in   4  unsigned operands
//   out            out  4  registered (input1+input2) mod 16
//   carry          out  1  registered bit 4 of the sum
//   out_valid      out  1  registered copy of in_valid
//   a..g           out  1  registered segment drives showing out
// Build option: define SEVSEG_ACTIVE_LOW_EN to invert all segment outputs
// (0 = lit, blank = all ones). out, carry and out_valid are unaffected.
module adder_seven_seg
  import adder_seven_seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] input1,
  input  logic [3:0] input2,
  output logic [3:0] out,
  output logic       carry,
  output logic       out_valid,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g
);

  // Maps an active-high pattern to the board's segment polarity.
  function automatic seg_t seg_polarity(input seg_t pat);
`ifdef SEVSEG_ACTIVE_LOW_EN
    return ~pat;
`else
    return pat;
`endif
  endfunction

  localparam seg_t SEG_RST = seg_polarity(SEG_BLANK);

  logic [4:0] sum_p0;
  seg_t       seg_p0;

  logic [3:0] sum_p1_d,   sum_p1_q;
  logic       carry_p1_d, carry_p1_q;
  seg_t       seg_p1_d,   seg_p1_q;
  logic       vld_p1_q;

  // ---- stage p0: add and decode the new sum ----
  assign sum_p0 = {1'b0, input1} + {1'b0, input2};

  seg7_decode u_dec (
    .nibble (sum_p0[3:0]),
    .seg    (seg_p0)
  );

  always_comb begin
    sum_p1_d   = sum_p1_q;
    carry_p1_d = carry_p1_q;
    seg_p1_d   = seg_p1_q;
    if (in_valid) begin
      sum_p1_d   = sum_p0[3:0];
      carry_p1_d = sum_p0[4];
      seg_p1_d   = seg_polarity(seg_p0);
    end
  end

  // ---- stage p1: output registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1_q   <= 4'd0;
      carry_p1_q <= 1'b0;
      seg_p1_q   <= SEG_RST;
      vld_p1_q   <= 1'b0;
    end else begin
      sum_p1_q   <= sum_p1_d;
      carry_p1_q <= carry_p1_d;
      seg_p1_q   <= seg_p1_d;
      vld_p1_q   <= in_valid;
    end
  end

  assign out       = sum_p1_q;
  assign carry     = carry_p1_q;
  assign out_valid = vld_p1_q;
  assign {a, b, c, d, e, f, g} = seg_p1_q;

endmodule

// File: tb/tb_adder_seven_seg.sv
module tb_adder_seven_seg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] input1, input2;
  logic [3:0] out;
  logic       carry, out_valid;
  logic       a, b, c, d, e, f, g;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference hex patterns {a..g}, active-high, typed in from the digit map.
  localparam logic [6:0] SEG_REF [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

`ifdef SEVSEG_ACTIVE_LOW_EN
  localparam logic [6:0] POL   = 7'b1111111;
`else
  localparam logic [6:0] POL   = 7'b0000000;
`endif

  adder_seven_seg dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .input1(input1), .input2(input2),
    .out(out), .carry(carry), .out_valid(out_valid),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [6:0] segs();
    return {a, b, c, d, e, f, g};
  endfunction

  // Drive one cycle of inputs at the falling edge, then settle past the rising edge.
  task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    in_valid = v;
    input1   = x;
    input2   = y;
    @(posedge clk);
    #1;
  endtask

  // Full output check against hand-supplied sum/carry; segments from the table.
  task automatic expect_all(input string tag, input logic [3:0] s, input logic cy, input logic v);
    check({tag, ".out"},   {28'd0, out},       {28'd0, s});
    check({tag, ".carry"}, {31'd0, carry},     {31'd0, cy});
    check({tag, ".vld"},   {31'd0, out_valid}, {31'd0, v});
    check({tag, ".segs"},  {25'd0, segs()},    {25'd0, SEG_REF[s] ^ POL});
  endtask

  task automatic expect_blank(input string tag);
    check({tag, ".out"},   {28'd0, out},       32'd0);
    check({tag, ".carry"}, {31'd0, carry},     32'd0);
    check({tag, ".vld"},   {31'd0, out_valid}, 32'd0);
    check({tag, ".segs"},  {25'd0, segs()},    {25'd0, POL});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; input1 = 4'd0; input2 = 4'd0;

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      input1 = 4'($urandom_range(0, 15));
      input2 = 4'($urandom_range(0, 15));
      #1 expect_blank("rst_hold");
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    drive(1'b0, 4'd6, 4'd2);
    expect_blank("rst_rel_idle");

    // Basic capture.
    drive(1'b1, 4'd1, 4'd3);
    expect_all("add_1_3", 4'b0100, 1'b0, 1'b1);
    check("add_1_3.raw_segs", {25'd0, segs()}, {25'd0, 7'b0110011 ^ POL});

    // Back-to-back captures.
    drive(1'b1, 4'd5, 4'd7);
    expect_all("b2b_5_7", 4'b1100, 1'b0, 1'b1);
    check("b2b_5_7.raw_segs", {25'd0, segs()}, {25'd0, 7'b1001110 ^ POL});
    drive(1'b1, 4'd5, 4'd3);
    expect_all("b2b_5_3", 4'b1000, 1'b0, 1'b1);
    drive(1'b1, 4'd0, 4'd7);
    expect_all("b2b_0_7", 4'b0111, 1'b0, 1'b1);

    // Hold: in_valid low, operands change.
    drive(1'b0, 4'd9, 4'd9);
    expect_all("hold", 4'b0111, 1'b0, 1'b0);
    drive(1'b0, 4'd15, 4'd1);
    expect_all("hold2", 4'b0111, 1'b0, 1'b0);

    // Overflow and carry clearing.
    drive(1'b1, 4'd9, 4'd11);
    expect_all("ovf_9_11", 4'b0100, 1'b1, 1'b1);
    drive(1'b1, 4'd15, 4'd15);
    expect_all("ovf_15_15", 4'hE, 1'b1, 1'b1);
    drive(1'b1, 4'd9, 4'd3);
    expect_all("add_9_3", 4'b1100, 1'b0, 1'b1);

    // Asynchronous reset mid-stream: outputs clear without a clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 expect_blank("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    drive(1'b0, 4'd3, 4'd3);
    expect_blank("post_rst_idle");
    drive(1'b1, 4'd2, 4'd2);
    expect_all("post_rst_cap", 4'd4, 1'b0, 1'b1);

    // Exhaustive sweep, back-to-back.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [4:0] s;
        s = 5'(i) + 5'(j);
        drive(1'b1, 4'(i), 4'(j));
        expect_all("sweep", s[3:0], s[4], 1'b1);
      end
    end
    drive(1'b0, 4'd0, 4'd0);
    expect_all("sweep_end", 4'hE, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
